// File: rtl/uart_rx_gpio_pkg.sv
// Shared definitions for the memory-mapped UART receiver: register map,
// status bit positions, receive FSM encoding and the baud divider helper.
`timescale 1ns/1ps
package uart_rx_gpio_pkg;

    localparam logic [3:0] ADDR_RX_DATA   = 4'b0101;
    localparam logic [3:0] ADDR_RX_STATUS = 4'b0110;

    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_FRAME_ERR = 2;
    localparam int ST_OVERRUN   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    // Clock cycles per 16x oversampling tick.
    function automatic int baud_div(input int clk_freq, input int baud);
        return clk_freq / (baud * 16);
    endfunction

endpackage

// File: rtl/uart_rx_gpio_if.sv
// CPU data-bus slice seen by the receiver: address, write data, strobes
// and the registered read data.
`timescale 1ns/1ps
interface uart_rx_gpio_if;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic        rd_strobe;
    logic [3:0]  wr_strobe;
    logic [31:0] data_out;

    modport master (output addr, data_in, rd_strobe, wr_strobe, input data_out);
    modport slave  (input addr, data_in, rd_strobe, wr_strobe, output data_out);
endinterface

// File: rtl/uart_rx_gpio_sync_fifo.sv
// Generic synchronous FIFO; a push into a full FIFO is accepted only when a
// pop in the same cycle frees the slot, otherwise it is dropped.
`timescale 1ns/1ps
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: storage is not reset; the count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
endmodule

// File: rtl/uart_rx_gpio.sv
// 8N1 UART receiver with 16x oversampling, receive FIFO and RX_DATA /
// RX_STATUS registers on the CPU data bus.
`timescale 1ns/1ps
module uart_rx_gpio
    import uart_rx_gpio_pkg::*;
#(
    parameter int CLK_FREQ   = 12_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_gpio_if.slave  bus,
    input  logic           rx_pin,
    output logic           rx_irq
);
    localparam int DIV = baud_div(CLK_FREQ, BAUD);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);

    logic [1:0]    sync_q;
    logic          rx_s;
    logic [CW-1:0] div_cnt;
    logic          tick;
    rx_state_e     state, state_next;
    logic [3:0]    s_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          push, frame_set;
    logic          overrun, frame_err;
    logic [7:0]    head;
    logic          full, empty;
    logic [AW:0]   fifo_count;
    logic [3:0]    nib;
    logic          rd_data, rd_status, pop, status_wr;
    logic          unused_ok;

    // Line idles high, so the synchroniser resets to 1 to avoid a false start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= 2'b11;
        else      sync_q <= {sync_q[0], rx_pin};
    end
    assign rx_s = sync_q[1];

    assign tick = (div_cnt == CW'(DIV - 1));
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        if (tick) begin
            case (state)
                IDLE:  if (!rx_s) state_next = START;
                START: if (s_cnt == 4'd7) state_next = rx_s ? IDLE : DATA;
                DATA:  if (s_cnt == 4'd15 && bit_idx == 3'd7) state_next = STOP;
                STOP:  if (s_cnt == 4'd15) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        push      = 1'b0;
        frame_set = 1'b0;
        if (tick && state == STOP && s_cnt == 4'd15) begin
            push      = rx_s;
            frame_set = !rx_s;
        end
    end

    // Sample counter, bit index and shift register; LSB arrives first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_cnt   <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else if (tick) begin
            case (state)
                IDLE:  s_cnt <= '0;
                START: begin
                    s_cnt   <= (s_cnt == 4'd7) ? 4'd0 : s_cnt + 1'b1;
                    bit_idx <= '0;
                end
                DATA: begin
                    s_cnt <= s_cnt + 1'b1;
                    if (s_cnt == 4'd15) begin
                        shift   <= {rx_s, shift[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
                STOP:  s_cnt <= s_cnt + 1'b1;
                default: s_cnt <= '0;
            endcase
        end
    end

    assign nib       = bus.addr[31:28];
    assign rd_data   = bus.rd_strobe && (nib == ADDR_RX_DATA);
    assign rd_status = bus.rd_strobe && (nib == ADDR_RX_STATUS);
    assign pop       = rd_data && !empty;
    assign status_wr = bus.wr_strobe[0] && (nib == ADDR_RX_STATUS);

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (shift),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    // Sticky flags: a set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (push && full && !pop)                          overrun <= 1'b1;
            else if (status_wr && bus.data_in[ST_OVERRUN])     overrun <= 1'b0;
            if (frame_set)                                     frame_err <= 1'b1;
            else if (status_wr && bus.data_in[ST_FRAME_ERR])   frame_err <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.data_out <= '0;
        end else if (rd_data) begin
            bus.data_out <= {24'b0, empty ? 8'h00 : head};
        end else if (rd_status) begin
            bus.data_out <= {28'b0, overrun, frame_err, full, !empty};
        end
    end

    assign rx_irq = (fifo_count != '0);

    assign unused_ok = &{1'b0, bus.addr[27:0], bus.data_in[31:4], bus.data_in[1:0],
                         bus.wr_strobe[3:1]};
endmodule

// File: tb/tb_uart_rx_gpio.sv
// Directed bench for uart_rx_gpio at DIV=2 (32 clk per bit); drives 8N1 frames
// and checks the register interface against hand-computed values.
`timescale 1ns/1ps
module tb_uart_rx_gpio;
    localparam logic [3:0] NIB_DATA   = 4'b0101;
    localparam logic [3:0] NIB_STATUS = 4'b0110;
    localparam int         BIT_CLK    = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx_pin = 1'b1;
    logic rx_irq;
    int   checks = 0;
    int   errors = 0;

    uart_rx_gpio_if bus ();

    uart_rx_gpio #(.CLK_FREQ(3_200_000), .BAUD(100_000), .FIFO_DEPTH(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .rx_pin (rx_pin),
        .rx_irq (rx_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic line(input logic level, input int n_clk);
        rx_pin = level;
        repeat (n_clk) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        line(1'b0, BIT_CLK);
        for (int i = 0; i < 8; i++) line(b[i], BIT_CLK);
        line(stop_bit, BIT_CLK);
        line(1'b1, 2 * BIT_CLK);
    endtask

    task automatic rd(input logic [3:0] nib, output logic [31:0] val);
        bus.addr      = {nib, 28'h0};
        bus.rd_strobe = 1'b1;
        @(negedge clk);
        bus.rd_strobe = 1'b0;
        val           = bus.data_out;
    endtask

    task automatic wr(input logic [3:0] nib, input logic [31:0] data);
        bus.addr      = {nib, 28'h0};
        bus.data_in   = data;
        bus.wr_strobe = 4'b0001;
        @(negedge clk);
        bus.wr_strobe = 4'b0000;
    endtask

    initial begin
        logic [31:0] v;
        int          n;

        bus.addr      = '0;
        bus.data_in   = '0;
        bus.rd_strobe = 1'b0;
        bus.wr_strobe = '0;

        // Reset state
        repeat (4) @(negedge clk);
        check("rst_data_out", bus.data_out, 32'h0);
        check("rst_irq", rx_irq, 32'h0);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rd(NIB_STATUS, v); check("rst_status", v, 32'h0);

        // 1: single byte
        send_frame(8'hA5, 1'b1);
        check("t1_irq_high", rx_irq, 32'h1);
        rd(NIB_STATUS, v); check("t1_status", v, 32'h1);
        rd(NIB_DATA, v);   check("t1_data", v, 32'hA5);
        check("t1_irq_low", rx_irq, 32'h0);
        rd(4'h1, v);       check("t1_unmapped_hold", v, 32'hA5);
        rd(NIB_STATUS, v); check("t1_status_empty", v, 32'h0);

        // 2: overrun on fifth byte
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        rd(NIB_STATUS, v); check("t2_status", v, 32'hB);
        rd(NIB_DATA, v);   check("t2_data0", v, 32'h01);
        rd(NIB_DATA, v);   check("t2_data1", v, 32'h02);
        rd(NIB_DATA, v);   check("t2_data2", v, 32'h03);
        rd(NIB_DATA, v);   check("t2_data3", v, 32'h04);
        rd(NIB_DATA, v);   check("t2_empty_read", v, 32'h0);
        wr(NIB_DATA, 32'hFFFF_FFFF);
        wr(NIB_STATUS, 32'h8);
        rd(NIB_STATUS, v); check("t2_overrun_clr", v, 32'h0);

        // 3: framing error
        send_frame(8'h3C, 1'b0);
        rd(NIB_STATUS, v); check("t3_status", v, 32'h4);
        check("t3_irq", rx_irq, 32'h0);
        wr(NIB_STATUS, 32'h4);
        rd(NIB_STATUS, v); check("t3_status_clr", v, 32'h0);

        // 4: short glitch
        line(1'b0, 4);
        line(1'b1, 12 * BIT_CLK);
        rd(NIB_STATUS, v); check("t4_status", v, 32'h0);
        check("t4_irq", rx_irq, 32'h0);

        // 5: pop coincides with push into a full FIFO
        for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b1);
        rd(NIB_STATUS, v); check("t5_full", v, 32'h3);
        fork
            send_frame(8'h15, 1'b1);
            begin
                n = 0;
                while (dut.push !== 1'b1 && n < 2000) begin
                    @(negedge clk);
                    n++;
                end
                check("t5_push_seen", 32'(n < 2000), 32'h1);
                rd(NIB_DATA, v); check("t5_pop_data", v, 32'h11);
            end
        join
        rd(NIB_STATUS, v); check("t5_status", v, 32'h3);
        rd(NIB_DATA, v);   check("t5_data1", v, 32'h12);
        rd(NIB_DATA, v);   check("t5_data2", v, 32'h13);
        rd(NIB_DATA, v);   check("t5_data3", v, 32'h14);
        rd(NIB_DATA, v);   check("t5_data4", v, 32'h15);
        rd(NIB_STATUS, v); check("t5_status_end", v, 32'h0);

        // 6: reset mid-frame
        send_frame(8'h77, 1'b1);
        rd(NIB_STATUS, v); check("t6_pre_status", v, 32'h1);
        line(1'b0, BIT_CLK);
        line(1'b1, 3 * BIT_CLK + BIT_CLK / 2);
        rst = 1'b0;
        #1;
        check("t6_rst_data_out", bus.data_out, 32'h0);
        check("t6_rst_irq", rx_irq, 32'h0);
        line(1'b1, 4);
        rst = 1'b1;
        line(1'b1, BIT_CLK / 2 + 5 * BIT_CLK + 2 * BIT_CLK);
        rd(NIB_STATUS, v); check("t6_post_status", v, 32'h0);
        send_frame(8'h5A, 1'b1);
        rd(NIB_DATA, v);   check("t6_data", v, 32'h5A);
        rd(NIB_STATUS, v); check("t6_status_end", v, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
